morse_emit_char: RTL and testbench

Morse character transmitter: accepts one character as an element count plus a dit/dah bit vector and drives a keyed `signal` line using the same timing parameters as the capture side. Timing is counted in `ce` ticks and follows standard Morse spacing:
- element gap: one dit
- character gap: one dah
- word gap: `word_time`

It sits between the text-to-Morse lookup and the output keyer, and completes the loop-back path into the character capture block.

---
 rtl/morse_emit_char_pkg.sv | 10 +
 rtl/morse_emit_char_counter.sv | 12 +
 rtl/morse_emit_char.sv | 93 +++++++++
 tb/tb_morse_emit_char.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/morse_emit_char_pkg.sv
// morse_emit_char_pkg: shared widths, FSM state type and the duration helper for the Morse emitter
package morse_emit_char_pkg;
  localparam int PULSE_CNT_W = 8;
  localparam int MAX_MORSE_LEN = 6;
  localparam int MORSE_LEN_W = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, MARK = 2'd1, SPACE = 2'd2, GAP = 2'd3} state_t;
  function automatic logic [PULSE_CNT_W-1:0] last_tick(input logic [PULSE_CNT_W-1:0] d);
    return d == '0 ? '0 : d - 1'b1;
  endfunction
endpackage

// File: rtl/morse_emit_char_counter.sv
// morse_emit_char_counter: W-bit tick counter; clk, ce (count enable), sclr (sync clear, priority), q (count)
module morse_emit_char_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         ce,
  input  logic         sclr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    q <= sclr ? '0 : ce ? q + 1'b1 : q;
endmodule

// File: rtl/morse_emit_char.sv
// morse_emit_char: keys one Morse character onto signal; in clk/rst/ce/start/len/dits_dahs/word_gap/dit_time/dah_time/word_time, out signal/busy/done/error
module morse_emit_char
  import morse_emit_char_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     start,
  input  logic [MORSE_LEN_W-1:0]   len,
  input  logic [MAX_MORSE_LEN-1:0] dits_dahs,
  input  logic                     word_gap,
  input  logic [PULSE_CNT_W-1:0]   dit_time,
  input  logic [PULSE_CNT_W-1:0]   dah_time,
  input  logic [PULSE_CNT_W-1:0]   word_time,
  output logic                     signal,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);
  state_t state;
  logic [MORSE_LEN_W-1:0] idx;
  logic [MAX_MORSE_LEN-1:0] dd_q;
  logic wg_q;
  logic [PULSE_CNT_W-1:0] dit_q, dah_q, word_q, dur, cnt;
  logic accept, tick_end;
  assign accept = start & ce & ~busy;
  assign dur = state == MARK ? (dd_q[idx] ? dah_q : dit_q) :
               state == SPACE ? dit_q : (wg_q ? word_q : dah_q);
  assign tick_end = ce & busy & (cnt == last_tick(dur));
  morse_emit_char_counter #(.W(PULSE_CNT_W)) u_cnt (
    .clk  (clk),
    .ce   (ce & busy),
    .sclr (accept | tick_end | rst),
    .q    (cnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      dd_q <= '0;
      wg_q <= 1'b0;
      dit_q <= '0;
      dah_q <= '0;
      word_q <= '0;
      signal <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      done <= 1'b0;
      error <= 1'b0;
      if (accept) begin
        idx <= len - 1'b1;
        dd_q <= dits_dahs;
        wg_q <= word_gap;
        dit_q <= dit_time;
        dah_q <= dah_time;
        word_q <= word_time;
        if (len > MORSE_LEN_W'(MAX_MORSE_LEN)) begin
          done <= 1'b1;
          error <= 1'b1;
        end else if (len != '0) begin
          state <= MARK;
          busy <= 1'b1;
          signal <= 1'b1;
        end else if (word_gap) begin
          state <= GAP;
          busy <= 1'b1;
        end else begin
          done <= 1'b1;
        end
      end else if (tick_end) begin
        case (state)
          MARK: begin
            signal <= 1'b0;
            state <= idx != '0 ? SPACE : GAP;
            idx <= idx != '0 ? idx - 1'b1 : idx;
          end
          SPACE: begin
            signal <= 1'b1;
            state <= MARK;
          end
          GAP: begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_morse_emit_char.sv
// tb_morse_emit_char: directed self-checking bench for morse_emit_char
module tb_morse_emit_char;
  import morse_emit_char_pkg::*;
  logic clk = 0, rst = 1, ce_all = 1, div = 0, start = 0, word_gap = 0;
  logic [1:0] ph = 0;
  logic ce;
  logic [MORSE_LEN_W-1:0] len = 0;
  logic [MAX_MORSE_LEN-1:0] dits_dahs = 0;
  logic [PULSE_CNT_W-1:0] dit_time = 0, dah_time = 0, word_time = 0;
  logic signal, busy, done, error;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) ph <= ph + 1'b1;
  assign ce = ce_all | (div & ph == 2'd0);
  morse_emit_char dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .len(len), .dits_dahs(dits_dahs),
    .word_gap(word_gap), .dit_time(dit_time), .dah_time(dah_time), .word_time(word_time),
    .signal(signal), .busy(busy), .done(done), .error(error)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic setup(input int l, input int d, input logic wg, input int dt, input int dh, input int wt);
    len = MORSE_LEN_W'(l);
    dits_dahs = MAX_MORSE_LEN'(d);
    word_gap = wg;
    dit_time = PULSE_CNT_W'(dt);
    dah_time = PULSE_CNT_W'(dh);
    word_time = PULSE_CNT_W'(wt);
  endtask
  task automatic go();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic interval(input string tag, input logic lvl, input int n);
    int ok = 0;
    repeat (n) begin
      ok += int'(signal === lvl && busy === 1'b1);
      @(negedge clk);
    end
    chk(tag, ok, n);
  endtask
  task automatic run_len(input logic lvl, input int bound, output int n);
    n = 0;
    while (signal === lvl && busy === 1'b1 && n < bound) begin
      n++;
      @(negedge clk);
    end
  endtask
  initial begin
    int n, w;
    repeat (2) @(negedge clk);
    chk("reset signal", signal, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset error", error, 0);
    rst = 0;
    @(negedge clk);
    // "A" .- with character gap
    setup(2, 'b01, 0, 2, 6, 14);
    go();
    interval("A mark1", 1, 2);
    interval("A space", 0, 2);
    interval("A mark2", 1, 6);
    interval("A gap", 0, 6);
    chk("A done", done, 1);
    chk("A busy off", busy, 0);
    chk("A error", error, 0);
    @(negedge clk);
    chk("A done width", done, 0);
    // "A" with word gap, then back-to-back start in the done cycle
    setup(2, 'b01, 1, 2, 6, 14);
    go();
    interval("Aw mark1", 1, 2);
    interval("Aw space", 0, 2);
    interval("Aw mark2", 1, 6);
    interval("Aw word gap", 0, 14);
    chk("Aw done", done, 1);
    setup(2, 'b01, 0, 2, 6, 14);
    go();
    chk("b2b signal", signal, 1);
    chk("b2b busy", busy, 1);
    interval("b2b mark1", 1, 2);
    interval("b2b space", 0, 2);
    interval("b2b mark2", 1, 6);
    interval("b2b gap", 0, 6);
    chk("b2b done", done, 1);
    // ce 1-in-4, single dah, start held high throughout
    @(negedge clk);
    ce_all = 0;
    div = 1;
    setup(1, 'b1, 0, 3, 9, 21);
    start = 1;
    w = 0;
    while (busy !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("div accept", busy, 1);
    run_len(1, 100, n);
    chk("div high clks", n, 36);
    run_len(0, 100, n);
    chk("div low clks", n, 36);
    chk("div done", done, 1);
    start = 0;
    div = 0;
    ce_all = 1;
    @(negedge clk);
    // len=0 with word gap
    setup(0, 0, 1, 2, 6, 14);
    go();
    interval("len0 wg gap", 0, 14);
    chk("len0 wg done", done, 1);
    @(negedge clk);
    // len=0 without word gap
    setup(0, 0, 0, 2, 6, 14);
    go();
    chk("len0 done", done, 1);
    chk("len0 busy", busy, 0);
    chk("len0 error", error, 0);
    @(negedge clk);
    // len over max
    setup(MAX_MORSE_LEN + 1, 'h3f, 0, 2, 6, 14);
    go();
    chk("ovf done", done, 1);
    chk("ovf error", error, 1);
    chk("ovf signal", signal, 0);
    chk("ovf busy", busy, 0);
    @(negedge clk);
    chk("ovf error width", error, 0);
    // reset mid-MARK
    setup(2, 'b01, 0, 2, 6, 14);
    go();
    chk("rst pre mark", signal, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst signal", signal, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(done === 1'b1 || signal === 1'b1);
    end
    chk("rst quiet", n, 0);
    go();
    interval("rst A mark1", 1, 2);
    interval("rst A space", 0, 2);
    interval("rst A mark2", 1, 6);
    interval("rst A gap", 0, 6);
    chk("rst A done", done, 1);
    @(negedge clk);
    // zero dit time, single dit
    setup(1, 'b0, 0, 0, 6, 14);
    go();
    interval("zero mark", 1, 1);
    interval("zero gap", 0, 6);
    chk("zero done", done, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
